cache_way_array: RTL

CACHE_WAY_ARRAY -- requirements
Module: cache_way_array

---
 rtl/cache_way_array.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cache_way_array.sv
// Set-associative way array: per-way data, tag and valid/dirty storage with byte-masked
// writes, read-first access, registered hit detection, and a set-by-set valid/dirty sweep.
module cache_way_array #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int SETS            = 1024,
  parameter int WAYS            = 2,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE / 8))
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  output logic                           ready,
  input  logic [ADDRESS_WIDTH-1:0]       address,
  input  logic [CACHE_LINE_SIZE-1:0]     data_in,
  input  logic [CACHE_LINE_SIZE/8-1:0]   byte_en,
  input  logic [WAYS-1:0]                wen_data,
  input  logic [WAYS-1:0]                wen_tag,
  input  logic [1:0]                     valid_dirty_in,
  input  logic                           inv_all,
  output logic                           rsp_valid,
  output logic [WAYS*CACHE_LINE_SIZE-1:0] data_out,
  output logic [WAYS*TAG_WIDTH-1:0]      tag_out,
  output logic [WAYS*2-1:0]              valid_dirty_out,
  output logic [WAYS-1:0]                hit,
  output logic                           hit_any
);

  localparam int LINE_BYTES  = CACHE_LINE_SIZE / 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int SET_BITS    = $clog2(SETS);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_SWEEP
  } state_t;

  state_t              state_reg, state_next;
  logic [SET_BITS-1:0] cnt_reg, cnt_next;
  logic                clearing;
  logic                accept;

  logic [SET_BITS-1:0]  acc_set;
  logic [TAG_WIDTH-1:0] acc_tag;

  assign acc_set = address[OFFSET_BITS +: SET_BITS];
  assign acc_tag = address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign accept  = req & ready;

  generate
    if (OFFSET_BITS > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^address[OFFSET_BITS-1:0];
    end
  endgenerate

  // State register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT, ST_SWEEP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == SET_BITS'(SETS - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (inv_all) begin
          state_next = ST_SWEEP;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    clearing = 1'b0;
    case (state_reg)
      ST_RUN:            ready    = 1'b1;
      ST_INIT, ST_SWEEP: clearing = 1'b1;
      default:           clearing = 1'b1;
    endcase
  end

  // Raw per-way read results from the array stage, packed by way
  logic [WAYS*CACHE_LINE_SIZE-1:0] data_rd;
  logic [WAYS*TAG_WIDTH-1:0]       tag_rd;
  logic [WAYS*2-1:0]               vd_rd;
  logic [WAYS-1:0]                 hit_next;
  logic                            pend_reg;
  logic [TAG_WIDTH-1:0]            tag_cmp_reg;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [CACHE_LINE_SIZE-1:0] data_mem [SETS];
      logic [TAG_WIDTH-1:0]       tag_mem  [SETS];
      logic [1:0]                 vd_mem   [SETS];
      logic [CACHE_LINE_SIZE-1:0] data_rd_reg;
      logic [TAG_WIDTH-1:0]       tag_rd_reg;
      logic [1:0]                 vd_rd_reg;

      // Read-first: the read register captures the contents before this edge's write
      always_ff @(posedge clk) begin
        if (accept) begin
          data_rd_reg <= data_mem[acc_set];
          if (wen_data[gi]) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
              if (byte_en[b]) begin
                data_mem[acc_set][b*8 +: 8] <= data_in[b*8 +: 8];
              end
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (accept) begin
          tag_rd_reg <= tag_mem[acc_set];
          if (wen_tag[gi]) begin
            tag_mem[acc_set] <= acc_tag;
          end
        end
      end

      // Valid/dirty shares a write port between the sweep and normal tag writes
      always_ff @(posedge clk) begin
        if (accept) begin
          vd_rd_reg <= vd_mem[acc_set];
        end
        if (clearing) begin
          vd_mem[cnt_reg] <= 2'b00;
        end else if (accept && wen_tag[gi]) begin
          vd_mem[acc_set] <= valid_dirty_in;
        end
      end

      assign data_rd[gi*CACHE_LINE_SIZE +: CACHE_LINE_SIZE] = data_rd_reg;
      assign tag_rd[gi*TAG_WIDTH +: TAG_WIDTH]              = tag_rd_reg;
      assign vd_rd[gi*2 +: 2]                               = vd_rd_reg;
      assign hit_next[gi] = vd_rd_reg[0] & (tag_rd_reg == tag_cmp_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg    <= 1'b0;
      tag_cmp_reg <= '0;
    end else begin
      pend_reg <= accept;
      if (accept) begin
        tag_cmp_reg <= acc_tag;
      end
    end
  end

  // Response registers hold their value between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid       <= 1'b0;
      data_out        <= '0;
      tag_out         <= '0;
      valid_dirty_out <= '0;
      hit             <= '0;
      hit_any         <= 1'b0;
    end else begin
      rsp_valid <= pend_reg;
      if (pend_reg) begin
        data_out        <= data_rd;
        tag_out         <= tag_rd;
        valid_dirty_out <= vd_rd;
        hit             <= hit_next;
        hit_any         <= |hit_next;
      end
    end
  end

endmodule
